// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths and channel encoding for the memory port arbiter
package mem_port_arbiter_pkg;

   localparam int ADDR_W        = 16;
   localparam int DATA_W        = 8;
   localparam int TAG_W_DEFAULT = 13;

   // Channel select: 0 = data memory pipeline, 1 = second requester
   typedef enum logic {
      CH_DATA = 1'b0,
      CH_AUX  = 1'b1
   } chan_t;

endpackage

// File: rtl/mem_resp_fifo.sv
// rtl/mem_resp_fifo.sv - in-order load-response buffer holding {src, tag, data}
module mem_resp_fifo
   import mem_port_arbiter_pkg::*;
#(
   parameter int TAG_W      = TAG_W_DEFAULT,
   parameter int RESP_DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push,
   input  logic [TAG_W+DATA_W:0]             push_payload,
   input  logic                              pop,
   output logic                              valid,
   output logic [TAG_W+DATA_W:0]             head,
   output logic [$clog2(RESP_DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int PTR_W = $clog2(RESP_DEPTH);

   logic [TAG_W+DATA_W:0] store [RESP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign valid  = (count != '0);
   assign do_pop = pop & valid;
   assign head   = store[rd_ptr];

   // Payload storage; written only on push so the head entry holds while stalled
   always_ff @(posedge clk) begin
      if (push) begin
         store[wr_ptr] <= push_payload;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-channel memory port arbiter with load-response buffer (MEM_PORT_ARB_RR_EN selects round-robin)
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TAG_W      = TAG_W_DEFAULT,
   parameter int RESP_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req0_store,
   input  logic [TAG_W-1:0]  req0_tag,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic              req1_store,
   input  logic [TAG_W-1:0]  req1_tag,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [TAG_W-1:0]  resp_tag,
   output logic              resp_src
);

   localparam int CNT_W = $clog2(RESP_DEPTH + 1);

   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   occupancy;
   logic             inflight;
   logic             inflight_src;
   logic [TAG_W-1:0] inflight_tag;
   logic             pop;
   logic             load_ok;
   logic             adm0;
   logic             adm1;
   logic             fire0;
   logic             fire1;
   logic             load_fire;
   chan_t            prio;

   assign pop = resp_valid & resp_ready;

   // Loads are admitted only while buffered + in-flight responses, net of this cycle's pop, leave room
   always_comb begin
      occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
      load_ok   = (occupancy < (CNT_W+1)'(RESP_DEPTH));
   end

   assign adm0 = req0_store | load_ok;
   assign adm1 = req1_store | load_ok;

   // A channel is ready when admissible and either it holds priority or the other side cannot fire
   assign req0_ready = ~rst & adm0 & ((prio == CH_DATA) | ~(req1_valid & adm1));
   assign req1_ready = ~rst & adm1 & ((prio == CH_AUX)  | ~(req0_valid & adm0));

   assign fire0     = req0_valid & req0_ready;
   assign fire1     = req1_valid & req1_ready;
   assign load_fire = mem_en & ~mem_we;

   // Memory port driven directly by the firing request
   always_comb begin
      mem_en    = fire0 | fire1;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (fire1) begin
         mem_we    = req1_store;
         mem_addr  = req1_addr;
         mem_wdata = req1_wdata;
      end else if (fire0) begin
         mem_we    = req0_store;
         mem_addr  = req0_addr;
         mem_wdata = req0_wdata;
      end
   end

`ifdef MEM_PORT_ARB_RR_EN
   // Round-robin pointer: the channel that did not fire last gets priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio <= CH_DATA;
      end else if (fire0) begin
         prio <= CH_AUX;
      end else if (fire1) begin
         prio <= CH_DATA;
      end
   end
`else
   assign prio = CH_DATA;
`endif

   // Track the load whose read data returns next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight     <= 1'b0;
         inflight_src <= 1'b0;
         inflight_tag <= '0;
      end else begin
         inflight <= load_fire;
         if (load_fire) begin
            inflight_src <= fire1;
            inflight_tag <= fire1 ? req1_tag : req0_tag;
         end
      end
   end

   mem_resp_fifo #(
      .TAG_W      (TAG_W),
      .RESP_DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk          (clk),
      .rst          (rst),
      .push         (inflight),
      .push_payload ({inflight_src, inflight_tag, mem_rdata}),
      .pop          (pop),
      .valid        (resp_valid),
      .head         ({resp_src, resp_tag, resp_data}),
      .count        (count)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int TAG_W = 13;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0_valid, req0_ready, req0_store;
   logic [15:0]      req0_addr;
   logic [7:0]       req0_wdata;
   logic [TAG_W-1:0] req0_tag;
   logic             req1_valid, req1_ready, req1_store;
   logic [15:0]      req1_addr;
   logic [7:0]       req1_wdata;
   logic [TAG_W-1:0] req1_tag;
   logic             mem_en, mem_we;
   logic [15:0]      mem_addr;
   logic [7:0]       mem_wdata;
   logic [7:0]       mem_rdata = 8'h00;
   logic             resp_valid, resp_ready, resp_src;
   logic [7:0]       resp_data;
   logic [TAG_W-1:0] resp_tag;

   int vectors = 0;
   int miscompares = 0;

   mem_port_arbiter #(.TAG_W(TAG_W), .RESP_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_store(req0_store), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_store(req1_store), .req1_tag(req1_tag),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_tag(resp_tag), .resp_src(resp_src)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] + a[15:8];
   endfunction

   // Synchronous-read memory model
   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= mem_byte(mem_addr);
   end

   task automatic idle_inputs();
      req0_valid = 0; req0_store = 0; req0_addr = '0; req0_wdata = '0; req0_tag = '0;
      req1_valid = 0; req1_store = 0; req1_addr = '0; req1_wdata = '0; req1_tag = '0;
      resp_ready = 0;
   endtask

   task automatic apply_reset();
      rst = 1;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1; resp_ready = 1;
      req0_valid = 1; req0_addr = 16'h0001; req0_tag = 13'h0011;
      req1_valid = 1; req1_addr = 16'h0002; req1_tag = 13'h0022;
      #1;
      vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req0_ready: got %b expected 0", req0_ready); end
      vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req1_ready: got %b expected 0", req1_ready); end
      vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en: got %b expected 0", mem_en); end
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
      @(negedge clk);
      rst = 0;
      #1;
      vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL first_arb_req0_ready: got %b expected 1", req0_ready); end
      vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL first_arb_req1_ready: got %b expected 0", req1_ready); end
      vectors++; if (mem_addr !== 16'h0001) begin miscompares++; $display("FAIL first_arb_addr: got %h expected 0001", mem_addr); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_continuous();
      int k0 = 0;
      int k1 = 0;
      logic win;
      logic [15:0] exp_addr;
      logic             q_src[$];
      logic [TAG_W-1:0] q_tag[$];
      logic [7:0]       q_data[$];
      apply_reset();
      resp_ready = 1;
      for (int c = 0; c < 9; c++) begin
         req0_valid = (c < 6); req0_store = 0;
         req1_valid = (c < 6); req1_store = 0;
         req0_addr = 16'h0010 + 16'(k0); req0_tag = TAG_W'(32'h100 + k0);
         req1_addr = 16'h0020 + 16'(k1); req1_tag = TAG_W'(32'h200 + k1);
         #1;
         if (c < 6) begin
`ifdef MEM_PORT_ARB_RR_EN
            win = c[0];
`else
            win = 1'b0;
`endif
            exp_addr = win ? req1_addr : req0_addr;
            vectors++; if (req0_ready !== !win) begin miscompares++; $display("FAIL cont_req0_ready c%0d: got %b expected %b", c, req0_ready, !win); end
            vectors++; if (req1_ready !== win) begin miscompares++; $display("FAIL cont_req1_ready c%0d: got %b expected %b", c, req1_ready, win); end
            vectors++; if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin miscompares++; $display("FAIL cont_mem c%0d: got en=%b addr=%h expected en=1 addr=%h", c, mem_en, mem_addr, exp_addr); end
            q_src.push_back(win);
            q_tag.push_back(win ? req1_tag : req0_tag);
            q_data.push_back(mem_byte(exp_addr));
            if (win) k1++; else k0++;
         end
         if (c >= 2 && c < 8) begin
            vectors++;
            if (resp_valid !== 1'b1 || resp_src !== q_src[0] || resp_tag !== q_tag[0] || resp_data !== q_data[0]) begin
               miscompares++;
               $display("FAIL cont_resp c%0d: got v=%b src=%b tag=%h data=%h expected v=1 src=%b tag=%h data=%h",
                        c, resp_valid, resp_src, resp_tag, resp_data, q_src[0], q_tag[0], q_data[0]);
            end
            void'(q_src.pop_front()); void'(q_tag.pop_front()); void'(q_data.pop_front());
         end else begin
            vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL cont_resp_idle c%0d: got %b expected 0", c, resp_valid); end
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      apply_reset();
      resp_ready = 0;
      req0_valid = 1; req0_store = 0; req0_addr = 16'h1234; req0_tag = 13'd1;
      #1;
      vectors++; if (req0_ready !== 1'b1 || mem_addr !== 16'h1234) begin miscompares++; $display("FAIL bp_issue1: got rdy=%b addr=%h expected rdy=1 addr=1234", req0_ready, mem_addr); end
      @(negedge clk);
      req0_addr = 16'h1235; req0_tag = 13'd2;
      #1;
      vectors++; if (req0_ready !== 1'b1 || mem_addr !== 16'h1235) begin miscompares++; $display("FAIL bp_issue2: got rdy=%b addr=%h expected rdy=1 addr=1235", req0_ready, mem_addr); end
      @(negedge clk);
      req0_addr = 16'h1236; req0_tag = 13'd3;
      for (int c = 2; c < 5; c++) begin
         #1;
         vectors++; if (req0_ready !== 1'b0 || mem_en !== 1'b0) begin miscompares++; $display("FAIL bp_hold c%0d: got rdy=%b en=%b expected rdy=0 en=0", c, req0_ready, mem_en); end
         vectors++; if (resp_valid !== 1'b1 || resp_tag !== 13'd1 || resp_data !== 8'h46) begin miscompares++; $display("FAIL bp_stable c%0d: got v=%b tag=%h data=%h expected v=1 tag=1 data=46", c, resp_valid, resp_tag, resp_data); end
         @(negedge clk);
      end
      resp_ready = 1;
      #1;
      vectors++; if (req0_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 16'h1236) begin miscompares++; $display("FAIL bp_issue3: got rdy=%b en=%b addr=%h expected rdy=1 en=1 addr=1236", req0_ready, mem_en, mem_addr); end
      @(negedge clk);
      req0_valid = 0;
      #1;
      vectors++; if (resp_valid !== 1'b1 || resp_tag !== 13'd2 || resp_data !== 8'h47) begin miscompares++; $display("FAIL bp_resp2: got v=%b tag=%h data=%h expected v=1 tag=2 data=47", resp_valid, resp_tag, resp_data); end
      @(negedge clk);
      #1;
      vectors++; if (resp_valid !== 1'b1 || resp_tag !== 13'd3 || resp_data !== 8'h48) begin miscompares++; $display("FAIL bp_resp3: got v=%b tag=%h data=%h expected v=1 tag=3 data=48", resp_valid, resp_tag, resp_data); end
      @(negedge clk);
      #1;
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: got %b expected 0", resp_valid); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_store_bypass();
      apply_reset();
      resp_ready = 0;
      req0_valid = 1; req0_addr = 16'h1234; req0_tag = 13'd1;
      @(negedge clk);
      req0_addr = 16'h1235; req0_tag = 13'd2;
      @(negedge clk);
      req0_addr = 16'h1236; req0_tag = 13'd3;
      req1_valid = 1; req1_store = 1; req1_addr = 16'h00FF; req1_wdata = 8'hA5; req1_tag = 13'd7;
      #1;
      vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL st_req0_ready: got %b expected 0", req0_ready); end
      vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL st_req1_ready: got %b expected 1", req1_ready); end
      vectors++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin miscompares++; $display("FAIL st_strobe: got en=%b we=%b expected en=1 we=1", mem_en, mem_we); end
      vectors++; if (mem_addr !== 16'h00FF || mem_wdata !== 8'hA5) begin miscompares++; $display("FAIL st_payload: got addr=%h wdata=%h expected addr=00ff wdata=a5", mem_addr, mem_wdata); end
      @(negedge clk);
      idle_inputs();
      resp_ready = 1;
      #1;
      vectors++; if (resp_valid !== 1'b1 || resp_tag !== 13'd1 || resp_src !== 1'b0) begin miscompares++; $display("FAIL st_resp1: got v=%b tag=%h src=%b expected v=1 tag=1 src=0", resp_valid, resp_tag, resp_src); end
      @(negedge clk);
      #1;
      vectors++; if (resp_valid !== 1'b1 || resp_tag !== 13'd2) begin miscompares++; $display("FAIL st_resp2: got v=%b tag=%h expected v=1 tag=2", resp_valid, resp_tag); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL st_no_store_resp c%0d: got %b expected 0", c, resp_valid); end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset_inflight();
      apply_reset();
      resp_ready = 1;
      req0_valid = 1; req0_addr = 16'h8000; req0_tag = 13'd5;
      #1;
      vectors++; if (mem_en !== 1'b1 || mem_addr !== 16'h8000) begin miscompares++; $display("FAIL rf_issue: got en=%b addr=%h expected en=1 addr=8000", mem_en, mem_addr); end
      @(negedge clk);
      rst = 1;
      #1;
      vectors++; if (req0_ready !== 1'b0 || mem_en !== 1'b0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL rf_async: got rdy=%b en=%b v=%b expected all 0", req0_ready, mem_en, resp_valid); end
      repeat (2) @(negedge clk);
      rst = 0;
      idle_inputs();
      resp_ready = 1;
      for (int c = 0; c < 4; c++) begin
         #1;
         vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rf_discard c%0d: got %b expected 0", c, resp_valid); end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a;
      apply_reset();
      resp_ready = 1;
      for (int c = 0; c < 9; c++) begin
         req0_valid = (c < 6); req0_addr = 16'h0040 + 16'(c); req0_tag = TAG_W'(32'h10 + c);
         #1;
         if (c < 6) begin
            vectors++; if (req0_ready !== 1'b1 || mem_addr !== req0_addr) begin miscompares++; $display("FAIL b2b_issue c%0d: got rdy=%b addr=%h expected rdy=1 addr=%h", c, req0_ready, mem_addr, req0_addr); end
         end
         if (c >= 2 && c < 8) begin
            a = 16'h0040 + 16'(c - 2);
            vectors++;
            if (resp_valid !== 1'b1 || resp_tag !== TAG_W'(32'h10 + c - 2) || resp_data !== mem_byte(a)) begin
               miscompares++;
               $display("FAIL b2b_resp c%0d: got v=%b tag=%h data=%h expected v=1 tag=%h data=%h", c, resp_valid, resp_tag, resp_data, TAG_W'(32'h10 + c - 2), mem_byte(a));
            end
         end else begin
            vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle c%0d: got %b expected 0", c, resp_valid); end
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_continuous();
      test_backpressure();
      test_store_bypass();
      test_reset_inflight();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TAG_W, default 13, width of the request/response tag ({dest_arch_regs, dest_reg}).
REQ-002 Parameter RESP_DEPTH, default 2, entries in the load-response buffer; 2 to 4.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 req0_valid/req0_ready  in/out  1/1  channel 0 handshake (data memory pipeline).
REQ-006 req0_addr, req0_wdata, req0_store, req0_tag  in  16, 8, 1, TAG_W  channel 0 payload.
REQ-007 req1_valid/req1_ready, req1_addr, req1_wdata, req1_store, req1_tag  as channel 0 (second requester).
REQ-008 mem_en, mem_we  out  1, 1  memory port access strobe; write enable.
REQ-009 mem_addr, mem_wdata  out  16, 8  memory port address and write data.
REQ-010 mem_rdata  in  8  synchronous read data, valid exactly one cycle after a read access.
REQ-011 resp_valid/resp_ready  out/in  1/1  load-response handshake.
REQ-012 resp_data, resp_tag, resp_src  out  8, TAG_W, 1  loaded byte, returned tag, originating channel.

Function
REQ-013 Handshake fires on a channel when valid & ready are both high in the same cycle; at most one channel fires per cycle.
REQ-014 A channel's ready depends on the other channel's valid and on resp_ready; it never depends on its own valid.
REQ-015 mem_* outputs are combinational from the firing request; mem_en = 1 exactly in the cycles where a handshake fires; mem_we = store of the winner.
REQ-016 Stores complete on issue and produce no response.
REQ-017 A load accepted in cycle N captures mem_rdata at the end of cycle N+1; resp_valid is high from cycle N+2 at the earliest.
REQ-018 In-flight flag: set in the cycle a load issues, cleared in the following cycle; back-to-back loads keep it set.
REQ-019 Load admission: a load issues only if count + inflight - (resp_valid & resp_ready) < RESP_DEPTH; stores ignore this limit.
REQ-020 A blocked load at the arbitration winner blocks that channel only; if the other channel holds an admissible request, that request is granted in the same cycle.
REQ-021 The response buffer is a FIFO; responses leave in issue order. Push and pop in the same cycle leave the count unchanged.
REQ-022 Overflow is impossible by REQ-019. Pop on empty is impossible because resp_valid = (count != 0).
REQ-023 Count and pointers wrap modulo RESP_DEPTH with no loss at the full/empty boundaries.
REQ-024 Response payload holds stable while resp_valid = 1 and resp_ready = 0.

Reset
REQ-025 While rst = 1: req0_ready = req1_ready = 0, mem_en = mem_we = 0, resp_valid = 0, count = 0, inflight = 0, priority pointer = channel 0.
REQ-026 Reset during an outstanding load discards that load; no response for it appears after reset is released.
REQ-027 The first arbitration after reset release favours channel 0.

Configuration
REQ-028 Macro MEM_PORT_ARB_RR_EN defined: round-robin arbitration. The channel that did not fire last has priority; the pointer updates only on a fire.
REQ-029 Macro MEM_PORT_ARB_RR_EN undefined: fixed priority, channel 0 always wins; no pointer flop exists.

Structure
REQ-030 The shared package holds the address width (16), data width (8), the default TAG_W, and the channel-select encoding (0 = data pipeline, 1 = second requester).
REQ-031 The response FIFO is one sub-module, mem_resp_fifo (payload {src, tag, data}, parameter RESP_DEPTH, count output); arbitration and admission logic stay in the top module.

Verification
REQ-032 Both channels issue continuous loads, RR enabled, resp_ready = 1 -> grants alternate 0,1,0,1; one response per cycle after the 2-cycle latency; tags match issue order.
REQ-033 Same stimulus with RR disabled -> channel 1 never granted while req0_valid = 1.
REQ-034 resp_ready = 0, channel 0 issues loads to 0x1234, 0x1235, 0x1236 (RESP_DEPTH = 2) -> two issue; third held with req0_ready = 0. On the first pop the third issues and is returned with its own address's byte.
REQ-035 Buffer full, channel 0 load blocked, channel 1 store to 0x00FF data 0xA5 -> the store issues that cycle with mem_we = 1; no response produced.
REQ-036 Load to 0x8000 issued, rst asserted in the next cycle -> outputs reach reset values immediately; resp_valid stays 0 after release.
REQ-037 Same-cycle push and pop with count = 1 -> count stays 1; response order preserved across pointer wrap.
